// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared constants and types for the multicycle MIPS control unit.
//   - opcode and funct field constants
//   - 3-bit ALUControl codes
//   - internal ALUOp encoding and FSM state encodings
package mc_ctrl_pkg;

  localparam int unsigned OP_W       = 6;
  localparam int unsigned FUNCT_W    = 6;
  localparam int unsigned ALU_CODE_W = 3;
  localparam int unsigned STATE_W    = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FUNCT_W-1:0] F_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] F_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] F_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] F_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] F_XOR = 6'h26;
  localparam logic [FUNCT_W-1:0] F_NOR = 6'h27;
  localparam logic [FUNCT_W-1:0] F_SLT = 6'h2A;

  localparam logic [ALU_CODE_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_CODE_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_CODE_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_CODE_W-1:0] ALU_XOR = 3'b011;
  localparam logic [ALU_CODE_W-1:0] ALU_NOR = 3'b100;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_IMM   = 2'b11
  } alu_op_e;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_IMMWB    = 4'd10,
    S_JUMP     = 4'd11,
    S_IMMEX    = 4'd12
  } state_e;

endpackage

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: combinational ALUOp/funct/op -> ALUControl decode.
// Optional build macro: MC_CTRL_EXT_EN (adds nor/xor funct decode).
// Ports:
//   alu_op_i        ALUOp from the control FSM
//   op_i            opcode, used for the immediate-logic ALUOp
//   funct_i         R-type funct field
//   alu_ctrl_o      ALU operation, zero-extended to ALUCTRL_W
//   illegal_funct_o unsupported funct while ALUOp selects funct decode
module mc_alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALUCTRL_W = 3
) (
  input  alu_op_e                alu_op_i,
  input  logic [OP_W-1:0]        op_i,
  input  logic [FUNCT_W-1:0]     funct_i,
  output logic [ALUCTRL_W-1:0]   alu_ctrl_o,
  output logic                   illegal_funct_o
);

  logic [ALU_CODE_W-1:0] code;

  always_comb begin
    code            = ALU_ADD;
    illegal_funct_o = 1'b0;
    unique case (alu_op_i)
      ALUOP_ADD: code = ALU_ADD;
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          F_ADD: code = ALU_ADD;
          F_SUB: code = ALU_SUB;
          F_AND: code = ALU_AND;
          F_OR:  code = ALU_OR;
          F_SLT: code = ALU_SLT;
`ifdef MC_CTRL_EXT_EN
          F_NOR: code = ALU_NOR;
          F_XOR: code = ALU_XOR;
`endif
          default: illegal_funct_o = 1'b1;
        endcase
      end
      ALUOP_IMM: begin
        // Only reachable from IMMEX; other opcodes fall back to add.
        if (op_i == OP_ANDI) begin
          code = ALU_AND;
        end else if (op_i == OP_ORI) begin
          code = ALU_OR;
        end
      end
      default: code = ALU_ADD;
    endcase
  end

  assign alu_ctrl_o = ALUCTRL_W'(code);

endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle MIPS control FSM with integrated ALU decode,
// memory-ready handshake, wait-timeout counter and illegal-instruction flag.
// Optional build macro: MC_CTRL_EXT_EN (andi/ori via IMMEX, nor/xor funct).
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   op, funct         instruction fields from the IR
//   zero              ALU zero flag (qualifies Branch into PCEn)
//   mem_ready         memory completes the current access this cycle
//   PCEn..PCSrc       datapath enables and mux selects (combinational)
//   ALUControl        ALU operation
//   ImmZeroExt        zero-extend immediate (extension only, else 0)
//   illegal, timeout  one-cycle event pulses
//   state             current state encoding for debug
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALUCTRL_W    = 3,
  parameter int unsigned WAIT_TIMEOUT = 0,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OP_W-1:0]      op,
  input  logic [FUNCT_W-1:0]   funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 PCEn,
  output logic                 IorD,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegDst,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           PCSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 ImmZeroExt,
  output logic                 illegal,
  output logic                 timeout,
  output logic [STATE_W-1:0]   state
);

  localparam bit             TO_EN  = (WAIT_TIMEOUT != 0);
  localparam logic [CNT_W:0] TO_LIM = (CNT_W+1)'(WAIT_TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;
  alu_op_e          alu_op;
  logic             pc_write, branch, illegal_op, illegal_funct, waiting;

  // Cycles stalled on memory; the increment is one bit wider for the compare.
  assign waiting = ((state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                    (state_q == S_MEMWRITE)) && !mem_ready;
  assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign timeout = TO_EN && !reset && waiting && (cnt_inc == TO_LIM);

  // Next-state and control decode.
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    branch     = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    ImmZeroExt = 1'b0;
    alu_op     = ALUOP_ADD;
    illegal_op = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ALUSrcB = 2'b01;
        if (mem_ready) begin
          IRWrite  = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_EXT_EN
          OP_ANDI, OP_ORI: state_d = S_IMMEX;
`endif
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        IorD = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_SUB;
        PCSrc   = 2'b01;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
`ifdef MC_CTRL_EXT_EN
      S_IMMEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        alu_op     = ALUOP_IMM;
        ImmZeroExt = 1'b1;
        state_d    = S_IMMWB;
      end
`endif
      default: state_d = S_FETCH;
    endcase
    // Aborted access: no strobe in the waiting states writes architectural state.
    if (timeout) state_d = S_FETCH;
    // Strobes are quiet while reset is held.
    if (reset) begin
      state_d    = S_FETCH;
      pc_write   = 1'b0;
      branch     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ImmZeroExt = 1'b0;
      illegal_op = 1'b0;
    end
  end

  // Counter restarts on any state change and after a timeout re-entering FETCH.
  always_comb begin
    cnt_d = cnt_q;
    if (reset || timeout || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (waiting) begin
      cnt_d = cnt_inc[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  mc_alu_decoder #(
    .ALUCTRL_W (ALUCTRL_W)
  ) u_alu_decoder (
    .alu_op_i        (alu_op),
    .op_i            (op),
    .funct_i         (funct),
    .alu_ctrl_o      (ALUControl),
    .illegal_funct_o (illegal_funct)
  );

  assign PCEn    = pc_write | (branch & zero);
  assign illegal = !reset && (illegal_op || ((state_q == S_EXECUTE) && illegal_funct));
  assign state   = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: directed self-checking bench for mc_control_unit
// (built with WAIT_TIMEOUT=3). Optional build macro: MC_CTRL_EXT_EN.
module tb_mc_control_unit;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic       ImmZeroExt, illegal, timeout;
  logic [3:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mc_control_unit #(
    .ALUCTRL_W    (3),
    .WAIT_TIMEOUT (3),
    .CNT_W        (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .PCEn       (PCEn),
    .IorD       (IorD),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .PCSrc      (PCSrc),
    .ALUControl (ALUControl),
    .ImmZeroExt (ImmZeroExt),
    .illegal    (illegal),
    .timeout    (timeout),
    .state      (state)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one cycle; sample 2ns after the edge, inputs settle 1ns later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int exp_lw[5];
    exp_lw = '{1, 2, 3, 4, 0};

    // Reset with mem_ready high: still in FETCH, no strobes.
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_state", state, 0);
    check("rst_irwrite", IRWrite, 0);
    check("rst_pcen", PCEn, 0);
    check("rst_illegal", illegal, 0);
    check("rst_timeout", timeout, 0);
    reset = 1'b0;

    // lw with mem_ready always high.
    op = OP_LW;
    #1;
    check("fetch_irwrite", IRWrite, 1);
    check("fetch_pcen", PCEn, 1);
    check("fetch_alusrcb", ALUSrcB, 1);
    check("fetch_aluctrl", ALUControl, 3'b010);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("lw_state", state, exp_lw[i]);
      check("lw_regwrite", RegWrite, (exp_lw[i] == 4) ? 1 : 0);
      check("lw_memtoreg", MemtoReg, (exp_lw[i] == 4) ? 1 : 0);
    end

    // R-type slt.
    op = OP_RTYPE; funct = F_SLT;
    tick(); check("slt_decode", state, 1);
    check("decode_alusrcb", ALUSrcB, 3);
    tick(); check("slt_exec", state, 6);
    check("slt_aluctrl", ALUControl, 3'b111);
    check("slt_illegal", illegal, 0);
    check("slt_alusrca", ALUSrcA, 1);
    tick(); check("slt_aluwb", state, 7);
    check("slt_regdst", RegDst, 1);
    check("slt_regwrite", RegWrite, 1);
    tick(); check("slt_back", state, 0);

    // R-type with unsupported funct 0x21.
    funct = 6'h21;
    tick(); tick();
    check("badf_exec", state, 6);
    check("badf_illegal", illegal, 1);
    check("badf_aluctrl", ALUControl, 3'b010);
    tick(); check("badf_illegal_gone", illegal, 0);
    tick(); check("badf_back", state, 0);

    // beq taken, then not taken.
    op = OP_BEQ; zero = 1'b1;
    tick(); tick();
    check("beq_state", state, 8);
    check("beq_pcen_taken", PCEn, 1);
    check("beq_pcsrc", PCSrc, 1);
    check("beq_aluctrl", ALUControl, 3'b110);
    tick(); check("beq_back", state, 0);
    zero = 1'b0;
    tick(); tick();
    check("beq_pcen_not_taken", PCEn, 0);
    tick(); check("beq_back2", state, 0);

    // addi: 1, 9, 10, 0.
    op = OP_ADDI;
    tick(); tick();
    check("addi_ex", state, 9);
    check("addi_alusrcb", ALUSrcB, 2);
    tick(); check("addi_wb", state, 10);
    check("addi_regwrite", RegWrite, 1);
    check("addi_regdst", RegDst, 0);
    tick(); check("addi_back", state, 0);

    // j: 1, 11, 0.
    op = OP_J;
    tick(); tick();
    check("j_state", state, 11);
    check("j_pcen", PCEn, 1);
    check("j_pcsrc", PCSrc, 2);
    tick(); check("j_back", state, 0);

    // Illegal opcode.
    op = 6'h3F;
    tick(); check("ill_decode", state, 1);
    check("ill_pulse", illegal, 1);
    tick(); check("ill_back", state, 0);
    check("ill_gone", illegal, 0);

    // Timeout while waiting in MEMREAD.
    op = OP_LW;
    tick(); tick(); tick();
    check("to_memread", state, 3);
    mem_ready = 1'b0;
    #1;
    check("to_wait1", timeout, 0);
    check("to_iord", IorD, 1);
    tick(); check("to_wait2_state", state, 3);
    check("to_wait2", timeout, 0);
    tick(); check("to_wait3", timeout, 1);
    check("to_no_regwrite", RegWrite, 0);
    tick(); check("to_back", state, 0);
    check("to_fetch_wait1", timeout, 0);

    // Timeout in FETCH re-enters FETCH with a cleared counter.
    tick(); check("tof_wait2", timeout, 0);
    tick(); check("tof_wait3", timeout, 1);
    check("tof_no_irwrite", IRWrite, 0);
    tick(); check("tof_state", state, 0);
    check("tof_restart1", timeout, 0);
    tick(); check("tof_restart2", timeout, 0);

    // mem_ready arriving on the would-be timeout cycle wins.
    tick();
    mem_ready = 1'b1;
    #1;
    check("race_timeout", timeout, 0);
    check("race_irwrite", IRWrite, 1);
    tick(); check("race_decode", state, 1);
    repeat (4) tick();
    check("race_lw_done", state, 0);

    // Reset while in MEMWRITE.
    op = OP_SW;
    tick(); tick();
    mem_ready = 1'b0;
    tick(); check("sw_memwrite", state, 5);
    check("sw_memwrite_strobe", MemWrite, 1);
    reset = 1'b1;
    #1;
    check("sw_rst_memwrite", MemWrite, 0);
    tick(); check("sw_rst_state", state, 0);
    reset = 1'b0;
    mem_ready = 1'b1;

    // ori: extension path or illegal.
    op = OP_ORI;
    tick(); check("ori_decode", state, 1);
`ifdef MC_CTRL_EXT_EN
    check("ori_legal", illegal, 0);
    tick(); check("ori_immex", state, 12);
    check("ori_aluctrl", ALUControl, 3'b001);
    check("ori_zext", ImmZeroExt, 1);
    tick(); check("ori_immwb", state, 10);
    check("ori_regwrite", RegWrite, 1);
    tick(); check("ori_back", state, 0);
`else
    check("ori_illegal", illegal, 1);
    check("ori_zext", ImmZeroExt, 0);
    tick(); check("ori_back", state, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
